iram_loader: RTL and testbench

IRAM_LOADER -- requirements
Module: iram_loader

---
 rtl/iram_pkg.sv | 21 ++
 rtl/iram_byte_packer.sv | 40 ++++
 rtl/iram_loader.sv | 110 +++++++++++
 tb/tb_iram_loader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/iram_pkg.sv
// rtl/iram_pkg.sv - shared state encoding, NOP word and geometry helpers for the instruction RAM loader
package iram_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // Wide enough for any sane instruction width; users slice the low DATA_W bits.
  localparam logic [255:0] NOP_WORD = '0;

  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int depth_words(input int addr_w, input int data_w);
    return (2 ** addr_w) / (data_w / 8);
  endfunction

endpackage

// File: rtl/iram_byte_packer.sv
// rtl/iram_byte_packer.sv - little-endian byte-to-word assembler feeding the instruction RAM
module iram_byte_packer
  import iram_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              accept,
  input  logic [7:0]        data,
  input  logic              last,
  output logic              write,
  output logic [DATA_W-1:0] word
);

  localparam int LANES = lane_count(DATA_W);
  localparam int LW    = $clog2(LANES);

  logic [LW-1:0]     lane;
  logic [DATA_W-1:0] acc;

  // acc only ever holds lanes below the current one, so unfilled upper lanes read as zero
  assign word  = acc | (DATA_W'(data) << {lane, 3'b000});
  assign write = accept && (last || lane == LW'(LANES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane <= '0;
      acc  <= '0;
    end else if (flush || write) begin
      lane <= '0;
      acc  <= '0;
    end else if (accept) begin
      acc  <= word;
      lane <= lane + 1'b1;
    end
  end

endmodule

// File: rtl/iram_loader.sv
// rtl/iram_loader.sv - byte-loaded instruction RAM with clear sweep, load and run phases
module iram_loader
  import iram_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] q,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic              reload,
  output logic              run,
  output logic [ADDR_W:0]   ld_words,
  output logic              err_ovf,
  output logic              misalign
);

  localparam int LANES = lane_count(DATA_W);
  localparam int LB    = $clog2(LANES);
  localparam int DEPTH = depth_words(ADDR_W, DATA_W);
  localparam int IW    = ADDR_W - LB;
  localparam logic [DATA_W-1:0] NOP = NOP_WORD[DATA_W-1:0];

  state_t            state, state_nx;
  logic [IW-1:0]     idx;
  logic [IW:0]       ptr;
  logic              err_q;
  logic              accept, full, pk_accept, pk_write;
  logic [DATA_W-1:0] pk_word;
  logic [DATA_W-1:0] mem [DEPTH];

  assign accept    = ld_valid && ld_ready;
  assign full      = (ptr == (IW + 1)'(DEPTH));
  assign pk_accept = accept && !full;

  iram_byte_packer #(.DATA_W(DATA_W)) u_packer (
    .clk    (clk),
    .reset  (reset),
    .flush  (state != ST_LOAD),
    .accept (pk_accept),
    .data   (ld_data),
    .last   (ld_last),
    .write  (pk_write),
    .word   (pk_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_CLEAR;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_CLEAR: if (idx == IW'(DEPTH - 1)) state_nx = ST_LOAD;
      ST_LOAD:  if (accept && ld_last)     state_nx = ST_RUN;
      ST_RUN:   if (reload)                state_nx = ST_CLEAR;
      default:                             state_nx = ST_CLEAR;
    endcase
  end

  always_comb begin
    ld_ready = 1'b0;
    run      = 1'b0;
    case (state)
      ST_LOAD: ld_ready = 1'b1;
      ST_RUN:  run      = 1'b1;
      default: ;
    endcase
  end

  // Pointer stops at DEPTH, which also gives the saturating word count for free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx   <= '0;
      ptr   <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: idx <= idx + 1'b1;
        ST_LOAD: begin
          if (accept && full) err_q <= 1'b1;
          if (pk_write)       ptr   <= ptr + 1'b1;
        end
        ST_RUN: if (reload) begin
          idx   <= '0;
          ptr   <= '0;
          err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) mem[idx] <= NOP;
    else if (pk_write)     mem[ptr[IW-1:0]] <= pk_word;
  end

  assign q        = run ? mem[addr[ADDR_W-1:LB]] : NOP;
  assign misalign = run && (addr[LB-1:0] != '0);
  assign ld_words = {{LB{1'b0}}, ptr};
  assign err_ovf  = err_q;

endmodule

// File: tb/tb_iram_loader.sv
// tb/tb_iram_loader.sv - self-checking bench for iram_loader against an image-level reference model
module tb_iram_loader;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int L      = DATA_W / 8;
  localparam int DEPTH  = (2 ** ADDR_W) / L;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [DATA_W-1:0] q;
  logic              ld_valid = 1'b0;
  logic [7:0]        ld_data = '0;
  logic              ld_last = 1'b0;
  logic              ld_ready;
  logic              reload = 1'b0;
  logic              run;
  logic [ADDR_W:0]   ld_words;
  logic              err_ovf;
  logic              misalign;

  int vectors = 0;
  int errors  = 0;

  logic [7:0]        img [$];
  logic [DATA_W-1:0] exp_mem [DEPTH];

  iram_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .q        (q),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .reload   (reload),
    .run      (run),
    .ld_words (ld_words),
    .err_ovf  (err_ovf),
    .misalign (misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: the image laid out little-endian from word 0, only the first DEPTH words kept
  task automatic build_model();
    for (int w = 0; w < DEPTH; w++) exp_mem[w] = '0;
    for (int i = 0; i < img.size(); i++)
      if (i < DEPTH * L) exp_mem[i / L][(i % L) * 8 +: 8] = img[i];
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ld_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", {31'd0, ld_ready}, 32'd1);
  endtask

  task automatic load_image(input bit gaps);
    for (int i = 0; i < img.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        ld_valid = 1'b0;
        @(negedge clk);
      end
      ld_valid = 1'b1;
      ld_data  = img[i];
      ld_last  = (i == img.size() - 1);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic check_run();
    int n, w, ew;
    n  = img.size();
    ew = (n + L - 1) / L;
    if (ew > DEPTH) ew = DEPTH;
    build_model();
    check("run", {31'd0, run}, 32'd1);
    check("ld_words", 32'(ld_words), 32'(ew));
    check("err_ovf", {31'd0, err_ovf}, {31'd0, (n > DEPTH * L)});
    for (int k = 0; k < DEPTH; k++) begin
      addr = ADDR_W'(k * L);
      #1;
      check("q_word", 32'(q), 32'(exp_mem[k]));
      check("misalign_aligned", {31'd0, misalign}, 32'd0);
    end
    w    = $urandom_range(0, DEPTH - 1);
    addr = ADDR_W'(w * L + 1);
    #1;
    check("misalign_odd", {31'd0, misalign}, 32'd1);
    check("q_odd", 32'(q), 32'(exp_mem[w]));
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    check("reload_run", {31'd0, run}, 32'd0);
    check("reload_err", {31'd0, err_ovf}, 32'd0);
    check("reload_words", 32'(ld_words), 32'd0);
    check("reload_q", 32'(q), 32'd0);
    wait_ready();
  endtask

  initial begin
    int lowcnt;
    bit bad;

    // reset held: everything quiet
    #12;
    check("rst_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_run", {31'd0, run}, 32'd0);
    check("rst_q", 32'(q), 32'd0);
    check("rst_words", 32'(ld_words), 32'd0);

    // clear sweep with ld_valid held high
    @(negedge clk);
    reset    = 1'b1;
    ld_valid = 1'b1;
    lowcnt   = 0;
    bad      = 1'b0;
    while (!ld_ready && lowcnt < 1000) begin
      if (run !== 1'b0 || q !== '0) bad = 1'b1;
      lowcnt++;
      @(negedge clk);
    end
    ld_valid = 1'b0;
    check("clear_cycles", 32'(lowcnt), 32'(DEPTH));
    check("clear_quiet", {31'd0, bad}, 32'd0);

    // four-byte image
    img = '{8'h01, 8'hF0, 8'h7F, 8'h51};
    load_image(1'b0);
    addr = 8'd0; #1;
    check("q_f001", 32'(q), 32'h0000F001);
    addr = 8'd2; #1;
    check("q_517f", 32'(q), 32'h0000517F);
    check_run();

    // partial last word
    do_reload();
    img = '{8'h01, 8'hF0, 8'hAB};
    load_image(1'b0);
    addr = 8'd3; #1;
    check("q_00ab_odd", 32'(q), 32'h000000AB);
    check("misalign_3", {31'd0, misalign}, 32'd1);
    check_run();

    // overflow image
    do_reload();
    img.delete();
    for (int i = 0; i < 258; i++) img.push_back(8'(i));
    load_image(1'b1);
    addr = ADDR_W'(127 * L); #1;
    check("q_word127", 32'(q), 32'h0000FFFE);
    check_run();

    // reload after overflow; small image must leave the rest zero
    do_reload();
    img = '{8'h12, 8'h34, 8'h56, 8'h78};
    load_image(1'b0);
    check_run();

    // random images
    for (int t = 0; t < 5; t++) begin
      int n;
      do_reload();
      n = $urandom_range(1, 270);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(8'($urandom));
      load_image(1'b1);
      check_run();
    end

    // reset mid-load after 3 of 4 bytes
    do_reload();
    img = '{8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_data  = img[i];
      @(negedge clk);
    end
    ld_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, ld_ready}, 32'd0);
    check("mid_rst_run", {31'd0, run}, 32'd0);
    check("mid_rst_q", 32'(q), 32'd0);
    check("mid_rst_words", 32'(ld_words), 32'd0);
    check("mid_rst_err", {31'd0, err_ovf}, 32'd0);
    check("mid_rst_misalign", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    wait_ready();
    img = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_image(1'b0);
    check_run();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
